// File: rtl/pia_6820_pkg.sv
// Shared constants for the Apple-1 PIA register block.
// Register offsets, the strobe bit position and the empty KBD read value.
package pia_6820_pkg;

  localparam logic [1:0] KBD   = 2'd0;
  localparam logic [1:0] KBDCR = 2'd1;
  localparam logic [1:0] DSP   = 2'd2;
  localparam logic [1:0] DSPCR = 2'd3;

  localparam int STROBE_BIT = 7;

  localparam logic [7:0] EMPTY_READ = 8'h80;

endpackage

// File: rtl/pia_6820_sync_fifo.sv
// Show-ahead synchronous FIFO holding keys until the CPU reads KBD.
// Ports: clk25, rst, push, pop, din, dout (head), empty, full.
module sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk25) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pia_6820.sv
// Apple-1 PIA at 0xD010-0xD013: KBD/KBDCR/DSP/DSPCR with a key FIFO.
// Ports: 6502 bus (cs/address/w_en/din/dout), key input, display handshake.
import pia_6820_pkg::*;

module pia_6820 #(
  parameter int KBD_FIFO_DEPTH = 4,
  parameter int KBD_FIFO_AW    = 2
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       enable,
  input  logic       cs,
  input  logic [1:0] address,
  input  logic       w_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [6:0] kbd_data,
  input  logic       kbd_valid,
  output logic       kbd_full,
  output logic [6:0] dsp_data,
  output logic       dsp_valid,
  input  logic       dsp_ready
);

  logic       bus_rd;
  logic       bus_wr;
  logic       pop;
  logic       empty;
  logic [6:0] head;
  logic [6:0] kbdcr;
  logic [6:0] dspcr;
  logic [7:0] rd_val;
  logic       handshake;
  logic       unused_din7;

  assign unused_din7 = din[STROBE_BIT];

  assign bus_rd    = cs & enable & ~w_en;
  assign bus_wr    = cs & enable & w_en;
  assign pop       = bus_rd & (address == KBD) & ~empty;
  assign handshake = dsp_valid & dsp_ready;

  sync_fifo #(
    .WIDTH (7),
    .DEPTH (KBD_FIFO_DEPTH),
    .AW    (KBD_FIFO_AW)
  ) u_fifo (
    .clk25 (clk25),
    .rst   (rst),
    .push  (kbd_valid),
    .pop   (pop),
    .din   (kbd_data),
    .dout  (head),
    .empty (empty),
    .full  (kbd_full)
  );

  always_comb begin
    rd_val = EMPTY_READ;
    unique case (address)
      KBD:     rd_val = empty ? EMPTY_READ : {1'b1, head};
      KBDCR:   rd_val = {~empty, kbdcr};
      DSP:     rd_val = {dsp_valid, dsp_data};
      DSPCR:   rd_val = {1'b0, dspcr};
      default: rd_val = EMPTY_READ;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) dout <= 8'h00;
    else     dout <= rd_val;
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      kbdcr <= '0;
      dspcr <= '0;
    end else if (bus_wr) begin
      if (address == KBDCR) kbdcr <= din[6:0];
      if (address == DSPCR) dspcr <= din[6:0];
    end
  end

  // A completing handshake beats a same-cycle DSP write; a write while
  // a character is still pending is dropped so dsp_data stays stable.
  always_ff @(posedge clk25) begin
    if (rst) begin
      dsp_valid <= 1'b0;
      dsp_data  <= '0;
    end else if (handshake) begin
      dsp_valid <= 1'b0;
    end else if (bus_wr && address == DSP && !dsp_valid) begin
      dsp_valid <= 1'b1;
      dsp_data  <= din[6:0];
    end
  end

endmodule

// File: tb/tb_pia_6820.sv
// Self-checking bench for pia_6820: directed steps plus random traffic.
// A queue-based model predicts dout, display and FIFO-full every cycle.
module tb_pia_6820;

  logic       clk25 = 1'b0;
  logic       rst, enable, cs, w_en, kbd_valid, dsp_ready;
  logic [1:0] address;
  logic [7:0] din, dout;
  logic [6:0] kbd_data, dsp_data;
  logic       kbd_full, dsp_valid;

  always #20 clk25 = ~clk25;

  pia_6820 #(.KBD_FIFO_DEPTH(4), .KBD_FIFO_AW(2)) dut (
    .clk25     (clk25),
    .rst       (rst),
    .enable    (enable),
    .cs        (cs),
    .address   (address),
    .w_en      (w_en),
    .din       (din),
    .dout      (dout),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .kbd_full  (kbd_full),
    .dsp_data  (dsp_data),
    .dsp_valid (dsp_valid),
    .dsp_ready (dsp_ready)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] q[$];
  logic       m_valid;
  logic [6:0] m_data, m_kbdcr, m_dspcr;
  logic [7:0] m_dout;
  logic       rdy;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic e, input logic [1:0] a,
                      input logic w, input logic [7:0] d, input logic kv,
                      input logic [6:0] kd, input logic rs);
    logic [7:0] rv;
    logic rd, wr;
    cs = c; enable = e; address = a; w_en = w; din = d;
    kbd_valid = kv; kbd_data = kd; dsp_ready = rdy; rst = rs;
    if (rs) begin
      q.delete();
      m_valid = 0; m_data = 0; m_kbdcr = 0; m_dspcr = 0; m_dout = 0;
    end else begin
      case (a)
        2'd0:    rv = (q.size() > 0) ? {1'b1, q[0]} : 8'h80;
        2'd1:    rv = {q.size() > 0, m_kbdcr};
        2'd2:    rv = {m_valid, m_data};
        default: rv = {1'b0, m_dspcr};
      endcase
      rd = c & e & ~w;
      wr = c & e & w;
      begin
        bit do_pop, do_push;
        do_pop  = rd && a == 0 && q.size() > 0;
        do_push = kv && q.size() < 4;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(kd);
      end
      if (wr && a == 1) m_kbdcr = d[6:0];
      if (wr && a == 3) m_dspcr = d[6:0];
      if (m_valid && rdy) m_valid = 0;
      else if (wr && a == 2 && !m_valid) begin
        m_valid = 1; m_data = d[6:0];
      end
      m_dout = rv;
    end
    @(posedge clk25);
    #1;
    chk("dout", dout, m_dout);
    chk("dsp_valid", {7'd0, dsp_valid}, {7'd0, m_valid});
    chk("dsp_data", {1'b0, dsp_data}, {1'b0, m_data});
    chk("kbd_full", {7'd0, kbd_full}, {7'd0, q.size() == 4});
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic rd(input logic [1:0] a);
    step(1, 1, a, 0, 0, 0, 0, 0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1, 1, a, 1, d, 0, 0, 0);
  endtask
  task automatic key(input logic [6:0] k);
    step(0, 1, 0, 0, 0, 1, k, 0);
  endtask

  initial begin
    rdy = 0;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_dout", dout, 8'h00);
    chk("rst_valid", {7'd0, dsp_valid}, 8'h00);
    chk("rst_full", {7'd0, kbd_full}, 8'h00);
    rd(1);
    chk("rst_kbdcr", dout, 8'h00);

    wr(1, 8'h05);
    key(7'h41);
    rd(1);
    chk("kbdcr_key", dout, 8'h85);
    rd(0);
    chk("kbd_read", dout, 8'hC1);
    rd(1);
    chk("kbdcr_after", dout, 8'h05);

    for (int i = 0; i < 5; i++) key(7'h31 + 7'(i));
    chk("ovf_full", {7'd0, kbd_full}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      rd(0);
      chk("ovf_read", dout, 8'hB1 + 8'(i));
    end
    rd(0);
    chk("ovf_empty", dout, 8'h80);

    wr(2, 8'h8D);
    chk("dsp_latch", {1'b0, dsp_data}, 8'h0D);
    rd(2);
    chk("dsp_read", dout, 8'h8D);
    wr(2, 8'h41);
    chk("dsp_ignored", {1'b0, dsp_data}, 8'h0D);
    rdy = 1;
    idle();
    chk("dsp_done", {7'd0, dsp_valid}, 8'h00);
    rdy = 0;
    rd(2);
    chk("dsp_read_clr", dout & 8'h80, 8'h00);

    key(7'h41);
    step(1, 1, 0, 0, 0, 1, 7'h42, 0);
    chk("simul_rd", dout, 8'hC1);
    rd(0);
    chk("simul_next", dout, 8'hC2);
    rd(0);
    chk("simul_empty", dout, 8'h80);

    wr(2, 8'h33);
    rdy = 1;
    wr(2, 8'h44);
    chk("hs_wins", {7'd0, dsp_valid}, 8'h00);
    rdy = 0;
    idle();
    chk("hs_dropped", {7'd0, dsp_valid}, 8'h00);

    step(1, 1, 0, 0, 0, 1, 7'h55, 0);
    chk("push_empty_rd", dout, 8'h80);
    rd(0);
    chk("push_empty_nxt", dout, 8'hD5);

    key(7'h61);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("en_nopop", dout, 8'hE1);
    step(1, 0, 2, 1, 8'h22, 0, 0, 0);
    chk("en_nolatch", {7'd0, dsp_valid}, 8'h00);
    step(1, 0, 3, 0, 0, 0, 0, 0);
    chk("en_dout_track", dout, 8'h00);
    rd(0);
    chk("en_pop", dout, 8'hE1);

    key(7'h11);
    wr(2, 8'h12);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    chk("mid_rst_dout", dout, 8'h00);
    chk("mid_rst_valid", {7'd0, dsp_valid}, 8'h00);

    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 1), $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), $urandom_range(0, 1),
           8'($urandom), $urandom_range(0, 1), 7'($urandom),
           $urandom_range(0, 63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
